// File: rtl/eu_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// eu_issue_arbiter_if
// Bundle of every handshake/data signal between the issue arbiter, the
// per-warp instruction buffers and the three execution units (IU, LSU, BRU).
//   slave  : arbiter view (consumes warp requests, drives EU registers)
//   master : environment view (warp buffers + EUs)
// Signal names carry the arbiter-relative _i/_o suffix.
// ---------------------------------------------------------------------------
interface eu_issue_arbiter_if #(
   parameter int NumWarps     = 8,
   parameter int PayloadWidth = 64
);
   localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

   // warp side
   logic [NumWarps-1:0]                   warp_valid_i;
   logic [NumWarps-1:0]                   warp_ready_o;
   logic [NumWarps-1:0][7:0]              warp_inst_i;    // {eu[1:0], subtype[5:0]}
   logic [NumWarps-1:0][PayloadWidth-1:0] warp_payload_i;

   // IU channel
   logic                    iu_valid_o;
   logic                    iu_ready_i;
   logic [5:0]              iu_subtype_o;
   logic [WidWidth-1:0]     iu_wid_o;
   logic [PayloadWidth-1:0] iu_payload_o;

   // LSU channel
   logic                    lsu_valid_o;
   logic                    lsu_ready_i;
   logic [5:0]              lsu_subtype_o;
   logic [WidWidth-1:0]     lsu_wid_o;
   logic [PayloadWidth-1:0] lsu_payload_o;

   // BRU channel
   logic                    bru_valid_o;
   logic                    bru_ready_i;
   logic [5:0]              bru_subtype_o;
   logic [WidWidth-1:0]     bru_wid_o;
   logic [PayloadWidth-1:0] bru_payload_o;

   // illegal-instruction report
   logic                    illegal_o;
   logic [WidWidth-1:0]     illegal_wid_o;

   modport slave (
      input  warp_valid_i, warp_inst_i, warp_payload_i,
      input  iu_ready_i, lsu_ready_i, bru_ready_i,
      output warp_ready_o,
      output iu_valid_o,  iu_subtype_o,  iu_wid_o,  iu_payload_o,
      output lsu_valid_o, lsu_subtype_o, lsu_wid_o, lsu_payload_o,
      output bru_valid_o, bru_subtype_o, bru_wid_o, bru_payload_o,
      output illegal_o, illegal_wid_o
   );

   modport master (
      output warp_valid_i, warp_inst_i, warp_payload_i,
      output iu_ready_i, lsu_ready_i, bru_ready_i,
      input  warp_ready_o,
      input  iu_valid_o,  iu_subtype_o,  iu_wid_o,  iu_payload_o,
      input  lsu_valid_o, lsu_subtype_o, lsu_wid_o, lsu_payload_o,
      input  bru_valid_o, bru_subtype_o, bru_wid_o, bru_payload_o,
      input  illegal_o, illegal_wid_o
   );
endinterface

// File: rtl/eu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// eu_issue_arbiter
// Issue-stage scheduler: each cycle picks at most one eligible warp by
// round-robin and routes its instruction into the one-entry output register
// of the EU named by its eu field. Illegal instructions are consumed and
// reported on illegal_o / illegal_wid_o instead of being issued.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : eu_issue_arbiter_if.slave (warp requests, IU/LSU/BRU
//             output registers, illegal report)
// ---------------------------------------------------------------------------

// Per-warp decode: legality of {eu, subtype} and eligibility for a grant.
module eu_issue_arbiter_lane (
   input  logic       valid_i,
   input  logic [1:0] eu_i,
   input  logic [5:0] subtype_i,
   input  logic [3:0] slot_free_i,   // bit 3 unused (eu=3 never legal)
   output logic       legal_o,
   output logic       elig_o
);
   always_comb begin
      legal_o = 1'b0;
      case (eu_i)
         2'd0:    legal_o = (subtype_i <= 6'h0E);
         2'd1:    legal_o = (subtype_i <= 6'h05);
         // only BNZ/BEZ; JMP and SYNC are resolved in the decoder
         2'd2:    legal_o = (subtype_i == 6'h02) || (subtype_i == 6'h03);
         default: legal_o = 1'b0;
      endcase
      // illegal instructions are always consumable; legal ones need a free slot
      elig_o = valid_i && (legal_o ? slot_free_i[eu_i] : 1'b1);
   end
endmodule

module eu_issue_arbiter #(
   parameter int NumWarps     = 8,
   parameter int PayloadWidth = 64
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   eu_issue_arbiter_if.slave  bus
);
   localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;
   localparam int CandW    = WidWidth + 1;
   localparam int NumEu    = 3;   // 0=IU, 1=LSU, 2=BRU

   // ---------------- per-warp decode ----------------
   logic [NumWarps-1:0][1:0] inst_eu;
   logic [NumWarps-1:0][5:0] inst_sub;
   logic [NumWarps-1:0]      legal;
   logic [NumWarps-1:0]      elig;
   logic [3:0]               slot_free;

   for (genvar w = 0; w < NumWarps; w++) begin : g_lane
      assign inst_eu[w]  = bus.warp_inst_i[w][7:6];
      assign inst_sub[w] = bus.warp_inst_i[w][5:0];

      eu_issue_arbiter_lane u_lane (
         .valid_i     (bus.warp_valid_i[w]),
         .eu_i        (inst_eu[w]),
         .subtype_i   (inst_sub[w]),
         .slot_free_i (slot_free),
         .legal_o     (legal[w]),
         .elig_o      (elig[w])
      );
   end

   // ---------------- EU slot state ----------------
   logic [NumEu-1:0]                   eu_rdy;
   logic [NumEu-1:0]                   vld_q, vld_d;
   logic [NumEu-1:0][5:0]              sub_q, sub_d;
   logic [NumEu-1:0][WidWidth-1:0]     wid_q, wid_d;
   logic [NumEu-1:0][PayloadWidth-1:0] pay_q, pay_d;

   assign eu_rdy = {bus.bru_ready_i, bus.lsu_ready_i, bus.iu_ready_i};
   // A full slot still counts as free when the EU drains it this cycle,
   // giving back-to-back issue without a bubble.
   assign slot_free = {1'b0, (~vld_q | eu_rdy)};

   // ---------------- round-robin pick ----------------
   logic [WidWidth-1:0] rr_q, rr_d;
   logic [CandW-1:0]    cand;
   logic                grant_vld;
   logic [WidWidth-1:0] grant_idx;

   // Scan from rr_q upward; cand is one bit wider so rr_q+k never overflows
   // before the modulo fold, which keeps non-power-of-two NumWarps correct.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NumWarps; k++) begin
         cand = {1'b0, rr_q} + CandW'(k);
         if (cand >= CandW'(NumWarps)) cand = cand - CandW'(NumWarps);
         if (!grant_vld && elig[cand[WidWidth-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[WidWidth-1:0];
         end
      end
   end

   logic       g_legal;
   logic [1:0] g_eu;
   assign g_legal = legal[grant_idx];
   assign g_eu    = inst_eu[grant_idx];

   // No handshake may complete while reset is held.
   assign bus.warp_ready_o = (grant_vld && rst_ni) ? (NumWarps'(1) << grant_idx) : '0;

   always_comb begin
      rr_d = rr_q;
      if (grant_vld) rr_d = (grant_idx == WidWidth'(NumWarps - 1)) ? '0 : grant_idx + 1'b1;
   end

   // ---------------- EU slot next state ----------------
   always_comb begin
      vld_d = vld_q;
      sub_d = sub_q;
      wid_d = wid_q;
      pay_d = pay_q;
      for (int e = 0; e < NumEu; e++) begin
         if (vld_q[e] && eu_rdy[e]) vld_d[e] = 1'b0;
         // a refill in the same cycle as a drain wins over the clear above
         if (grant_vld && g_legal && (g_eu == 2'(e))) begin
            vld_d[e] = 1'b1;
            sub_d[e] = inst_sub[grant_idx];
            wid_d[e] = grant_idx;
            pay_d[e] = bus.warp_payload_i[grant_idx];
         end
      end
   end

   // ---------------- illegal report ----------------
   logic                ill_q, ill_d;
   logic [WidWidth-1:0] ill_wid_q, ill_wid_d;

   always_comb begin
      ill_d     = grant_vld && !g_legal;
      ill_wid_d = ill_d ? grant_idx : ill_wid_q;
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q      <= '0;
         vld_q     <= '0;
         sub_q     <= '0;
         wid_q     <= '0;
         pay_q     <= '0;
         ill_q     <= 1'b0;
         ill_wid_q <= '0;
      end else begin
         rr_q      <= rr_d;
         vld_q     <= vld_d;
         sub_q     <= sub_d;
         wid_q     <= wid_d;
         pay_q     <= pay_d;
         ill_q     <= ill_d;
         ill_wid_q <= ill_wid_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.iu_valid_o    = vld_q[0];
   assign bus.iu_subtype_o  = sub_q[0];
   assign bus.iu_wid_o      = wid_q[0];
   assign bus.iu_payload_o  = pay_q[0];

   assign bus.lsu_valid_o   = vld_q[1];
   assign bus.lsu_subtype_o = sub_q[1];
   assign bus.lsu_wid_o     = wid_q[1];
   assign bus.lsu_payload_o = pay_q[1];

   assign bus.bru_valid_o   = vld_q[2];
   assign bus.bru_subtype_o = sub_q[2];
   assign bus.bru_wid_o     = wid_q[2];
   assign bus.bru_payload_o = pay_q[2];

   assign bus.illegal_o     = ill_q;
   assign bus.illegal_wid_o = ill_wid_q;
endmodule

// File: doc/eu_issue_arbiter.md
Name: eu_issue_arbiter

Overview:
- Issue-stage scheduler between the per-warp instruction buffers and the three execution units (IU, LSU, BRU).
- Each cycle it selects at most one ready warp instruction by round-robin and routes it by its eu field into a one-entry output register for that EU.
- It rejects subtypes that must never reach an EU.
- A stalled EU blocks only warps targeting that EU, never the others.

Parameters:
- NumWarps, 8, number of warp request ports (>=2).
- WidWidth, max(1,$clog2(NumWarps)), width of warp ID (derived, not overridden).
- PayloadWidth, 64, opaque per-instruction operand/tag payload forwarded unchanged.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- warp_valid_i  in  NumWarps  warp w holds an instruction.
- warp_ready_o  out  NumWarps  one-hot (or zero) grant; handshake on valid&ready.
- warp_inst_i  in  NumWarps x 8  per-warp {eu[1:0], subtype[5:0]} (inst_t).
- warp_payload_i  in  NumWarps x PayloadWidth  per-warp payload.
- iu_valid_o / lsu_valid_o / bru_valid_o  out  1 each  EU output register full.
- iu_ready_i / lsu_ready_i / bru_ready_i  in  1 each  EU accepts.
- iu_subtype_o / lsu_subtype_o / bru_subtype_o  out  6 each  registered subtype.
- iu_wid_o / lsu_wid_o / bru_wid_o  out  WidWidth each  originating warp ID.
- iu_payload_o / lsu_payload_o / bru_payload_o  out  PayloadWidth each  registered payload.
- illegal_o  out  1  one-cycle pulse: an illegal instruction was consumed.
- illegal_wid_o  out  WidWidth  warp ID of that instruction; held until the next illegal event.

Behaviour:
- Reset (async, rst_ni=0): all three EU valid_o=0, EU data outputs=0, rr_q=0, illegal_o=0, illegal_wid_o=0. Reset mid-operation drops buffered instructions. No handshake is completed in the reset cycle.
- Legality:
  - eu=IU: legal iff subtype<=0x0E.
  - eu=LSU: legal iff subtype<=0x05.
  - eu=BRU: legal iff subtype in {0x02 BNZ, 0x03 BEZ}. JMP and SYNC are illegal here; the decoder handles them.
  - eu=2'b11: illegal.
- EU slot free for EU e: valid_o[e]=0, or ready_i[e]=1 in the same cycle (pass-through refill allowed, full throughput of 1 per cycle per EU).
- Warp w is eligible iff warp_valid_i[w] and one of:
  - the instruction is legal and its EU slot is free; or
  - the instruction is illegal (always eligible, consumed).
- Arbitration: scan eligible warps from index rr_q upward modulo NumWarps; the first hit is granted.
  - warp_ready_o[grant]=1; all others 0.
  - At most one grant per cycle, across all EUs.
  - On a grant, rr_q <= (grant+1) mod NumWarps (wrap from NumWarps-1 to 0). No grant: rr_q holds.
- Combinational paths: warp_ready_o depends on warp_valid_i, warp_inst_i and the EU ready_i. No combinational path from warp inputs to any EU output.
- Legal grant to EU e: next cycle valid_o[e]=1 with subtype, wid=grant and payload registered. Latency is exactly 1 cycle from handshake to EU valid.
- Illegal grant: nothing is written to any EU. Next cycle illegal_o=1 and illegal_wid_o=grant. illegal_o deasserts the following cycle unless another illegal grant occurs.
- EU handshake: valid_o[e]&ready_i[e] empties slot e unless it is refilled in the same cycle.
- While valid_o[e]=1 and ready_i[e]=0, the outputs of e are stable.
- Independence: a full, stalled EU makes only warps targeting it ineligible. Those warps keep their request and lose no priority beyond the normal rr_q update.
- No fairness starvation: a continuously eligible warp is granted within NumWarps cycles.
- Inputs at or after rr_q with warp_valid_i=0 are skipped. All warps invalid: no grant, state holds.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with iu_valid_o=1 -> iu/lsu/bru_valid_o=0 and illegal_o=0 immediately; after release, the first grant goes to warp 0 when warps 0..7 are all valid.
- Round-robin: NumWarps=8, all warps valid with IU ADD, iu_ready_i=1 -> grants 0,1,2,...,7,0 on consecutive cycles; iu_wid_o follows one cycle later; one IU instruction every cycle.
- Stall isolation: iu_ready_i=0 with the IU slot full; warp 2 requests IU ADDI, warp 5 requests LSU LOAD_WORD -> warp 5 granted, lsu_valid_o=1 with lsu_wid_o=5 next cycle; warp 2 ready stays 0 until iu_ready_i=1.
- Illegal: warp 3 sends BRU_JMP (eu=2, subtype=0x00) -> warp_ready_o[3]=1; bru_valid_o stays 0; illegal_o=1 with illegal_wid_o=3 next cycle for one cycle. Repeat for eu=3 and for IU subtype 0x0F.
- Backpressure hold: lsu_ready_i=0 for 5 cycles after a fill -> lsu_subtype_o, lsu_wid_o and lsu_payload_o stable. Then lsu_ready_i=1 with a new LSU request pending -> refilled in the same cycle, no bubble.
- Wrap: rr_q=7, only warps 7 and 1 valid -> warp 7 granted, then warp 1; rr_q ends at 2.
